// File: rtl/fetch_arb_pkg.sv
// Shared types and default widths for the instruction-fetch bus arbiter.
package fetch_arb_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    typedef logic way_t;

    localparam way_t WAY0 = 1'b0;
    localparam way_t WAY1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer records the way served last.
module rr_arbiter2
    import fetch_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_c_o
);

    way_t last_q;
    way_t last_d;

    // Contention goes to the way that was not served last.
    always_comb begin
        grant_c_o    = 2'b00;
        grant_c_o[0] = req_i[0] & (~req_i[1] | (last_q == WAY1));
        grant_c_o[1] = req_i[1] & (~req_i[0] | (last_q == WAY0));
        last_d       = last_q;
        if (advance_i && (grant_c_o != 2'b00)) begin
            last_d = grant_c_o[1] ? WAY1 : WAY0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= WAY1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fetch_bus_arbiter.sv
// Shares one fetch bus between two ways: round-robin grant, single outstanding
// transaction, flush-aware response routing. FETCH_ARB_TIMEOUT_EN adds a DATA watchdog.
module fetch_bus_arbiter
    import fetch_arb_pkg::*;
#(
    parameter int unsigned AddrWidth     = ADDR_WIDTH_DEF,
    parameter int unsigned DataWidth     = DATA_WIDTH_DEF,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_w0_i,
    input  logic                 req_w1_i,
    input  logic [AddrWidth-1:0] addr_w0_i,
    input  logic [AddrWidth-1:0] addr_w1_i,
    input  logic                 flush_w0_i,
    input  logic                 flush_w1_i,
    output logic                 grant_w0_o,
    output logic                 grant_w1_o,
    output logic                 rvalid_w0_o,
    output logic                 rvalid_w1_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 bus_req_o,
    output logic [AddrWidth-1:0] bus_addr_o,
    input  logic                 bus_ready_i,
    input  logic                 bus_rvalid_i,
    input  logic [DataWidth-1:0] bus_rdata_i,
    output logic                 err_o
);

    state_e               state_q,   state_d;
    way_t                 owner_q,   owner_d;
    logic                 drop_q,    drop_d;
    logic                 bus_req_q, bus_req_d;
    logic [AddrWidth-1:0] bus_addr_q, bus_addr_d;
    logic [1:0]           grant_q,   grant_d;
    logic [1:0]           rvalid_q,  rvalid_d;
    logic [DataWidth-1:0] rdata_q,   rdata_d;
    logic                 err_q,     err_d;
    logic [1:0]           arb_req_c;
    logic [1:0]           arb_grant_c;
    logic                 flush_owner_c;

`ifdef FETCH_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    logic [CntW-1:0] cnt_q, cnt_d;
`else
    logic timeout_unused;
    assign timeout_unused = (TimeoutCycles == 32'd0);
`endif

    // A way flushing in the same cycle as its request is not eligible.
    assign arb_req_c     = {req_w1_i & ~flush_w1_i, req_w0_i & ~flush_w0_i};
    assign flush_owner_c = (owner_q == WAY1) ? flush_w1_i : flush_w0_i;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (arb_req_c),
        .advance_i (state_q == IDLE),
        .grant_c_o (arb_grant_c)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        drop_d     = drop_q;
        bus_req_d  = bus_req_q;
        bus_addr_d = bus_addr_q;
        grant_d    = 2'b00;
        rvalid_d   = 2'b00;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
`ifdef FETCH_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (arb_grant_c != 2'b00) begin
                    state_d    = ADDR;
                    owner_d    = arb_grant_c[1] ? WAY1 : WAY0;
                    drop_d     = 1'b0;
                    bus_req_d  = 1'b1;
                    bus_addr_d = arb_grant_c[1] ? addr_w1_i : addr_w0_i;
                    grant_d    = arb_grant_c;
                end
            end
            ADDR: begin
                if (flush_owner_c) begin
                    drop_d = 1'b1;
                end
                if (bus_ready_i) begin
                    state_d   = DATA;
                    bus_req_d = 1'b0;
`ifdef FETCH_ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            DATA: begin
                if (bus_rvalid_i) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!(drop_q || flush_owner_c)) begin
                        rdata_d           = bus_rdata_i;
                        rvalid_d[owner_q] = 1'b1;
                    end
                end else begin
                    if (flush_owner_c) begin
                        drop_d = 1'b1;
                    end
`ifdef FETCH_ARB_TIMEOUT_EN
                    // Watchdog: abandon a response that never arrives.
                    if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                        state_d = IDLE;
                        drop_d  = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_q    <= WAY0;
            drop_q     <= 1'b0;
            bus_req_q  <= 1'b0;
            bus_addr_q <= '0;
            grant_q    <= 2'b00;
            rvalid_q   <= 2'b00;
            rdata_q    <= '0;
            err_q      <= 1'b0;
`ifdef FETCH_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            drop_q     <= drop_d;
            bus_req_q  <= bus_req_d;
            bus_addr_q <= bus_addr_d;
            grant_q    <= grant_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
`ifdef FETCH_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign grant_w0_o  = grant_q[0];
    assign grant_w1_o  = grant_q[1];
    assign rvalid_w0_o = rvalid_q[0];
    assign rvalid_w1_o = rvalid_q[1];
    assign rdata_o     = rdata_q;
    assign bus_req_o   = bus_req_q;
    assign bus_addr_o  = bus_addr_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_fetch_bus_arbiter.sv
// Directed bench for fetch_bus_arbiter; define FETCH_ARB_TIMEOUT_EN for both
// DUT and bench to exercise the watchdog.
module tb_fetch_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_w0, req_w1, flush_w0, flush_w1;
    logic [AW-1:0] addr_w0, addr_w1;
    logic          grant_w0, grant_w1, rvalid_w0, rvalid_w1;
    logic [DW-1:0] rdata;
    logic          bus_req;
    logic [AW-1:0] bus_addr;
    logic          bus_ready, bus_rvalid;
    logic [DW-1:0] bus_rdata;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_bus_arbiter #(
        .AddrWidth     (AW),
        .DataWidth     (DW),
        .TimeoutCycles (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_w0_i     (req_w0),
        .req_w1_i     (req_w1),
        .addr_w0_i    (addr_w0),
        .addr_w1_i    (addr_w1),
        .flush_w0_i   (flush_w0),
        .flush_w1_i   (flush_w1),
        .grant_w0_o   (grant_w0),
        .grant_w1_o   (grant_w1),
        .rvalid_w0_o  (rvalid_w0),
        .rvalid_w1_o  (rvalid_w1),
        .rdata_o      (rdata),
        .bus_req_o    (bus_req),
        .bus_addr_o   (bus_addr),
        .bus_ready_i  (bus_ready),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata),
        .err_o        (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " grant"},  64'({grant_w0, grant_w1}), 64'd0);
        check({tag, " rvalid"}, 64'({rvalid_w0, rvalid_w1}), 64'd0);
        check({tag, " err"},    64'(err), 64'd0);
    endtask

    task automatic clear_inputs();
        req_w0 = 0; req_w1 = 0; flush_w0 = 0; flush_w1 = 0;
        addr_w0 = '0; addr_w1 = '0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        apply_reset();
        check_quiet("reset");
        check("reset bus_req",  64'(bus_req), 64'd0);
        check("reset bus_addr", 64'(bus_addr), 64'd0);
        check("reset rdata",    64'(rdata), 64'd0);

        // Single way0 fetch
        req_w0 = 1; addr_w0 = 32'h100;
        tick();
        req_w0 = 0;
        check("t1 grant_w0", 64'(grant_w0), 64'd1);
        check("t1 grant_w1", 64'(grant_w1), 64'd0);
        check("t1 bus_req",  64'(bus_req), 64'd1);
        check("t1 bus_addr", 64'(bus_addr), 64'h100);
        tick();
        check("t1 grant once", 64'(grant_w0), 64'd0);
        check("t1 addr hold",  64'(bus_req), 64'd1);
        bus_ready = 1;
        tick();
        bus_ready = 0;
        check("t1 bus_req drop", 64'(bus_req), 64'd0);
        tick();
        bus_rvalid = 1; bus_rdata = 32'hDEADBEEF;
        tick();
        bus_rvalid = 0;
        check("t1 rvalid_w0", 64'(rvalid_w0), 64'd1);
        check("t1 rvalid_w1", 64'(rvalid_w1), 64'd0);
        check("t1 rdata",     64'(rdata), 64'hDEADBEEF);
        tick();
        check("t1 rvalid pulse", 64'(rvalid_w0), 64'd0);

        // Both ways requesting continuously: grants alternate from way0
        apply_reset();
        req_w0 = 1; req_w1 = 1; addr_w0 = 32'h0; addr_w1 = 32'h4;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2 grant_w0", 64'(grant_w0), 64'((i % 2) == 0));
            check("t2 grant_w1", 64'(grant_w1), 64'((i % 2) == 1));
            check("t2 bus_addr", 64'(bus_addr), ((i % 2) == 1) ? 64'h4 : 64'h0);
            bus_ready = 1;
            tick();
            bus_ready = 0;
            check("t2 no grant in data", 64'({grant_w0, grant_w1}), 64'd0);
            bus_rvalid = 1; bus_rdata = 32'hA000 + 32'(i);
            tick();
            bus_rvalid = 0;
            check("t2 rvalid_w0", 64'(rvalid_w0), 64'((i % 2) == 0));
            check("t2 rvalid_w1", 64'(rvalid_w1), 64'((i % 2) == 1));
            check("t2 rdata",     64'(rdata), 64'(32'hA000 + 32'(i)));
            check("t2 no grant in resp", 64'({grant_w0, grant_w1}), 64'd0);
        end
        req_w0 = 0; req_w1 = 0;
        tick();

        // way1 owns, flush in DATA drops the response
        req_w1 = 1; addr_w1 = 32'h200;
        tick();
        req_w1 = 0;
        check("t3 grant_w1", 64'(grant_w1), 64'd1);
        bus_ready = 1;
        tick();
        bus_ready = 0;
        flush_w1 = 1;
        tick();
        flush_w1 = 0;
        bus_rvalid = 1; bus_rdata = 32'h0BAD;
        tick();
        bus_rvalid = 0;
        check_quiet("t3 dropped");
        req_w0 = 1; addr_w0 = 32'h300;
        tick();
        req_w0 = 0;
        check("t3 next grant_w0", 64'(grant_w0), 64'd1);
        check("t3 next bus_addr", 64'(bus_addr), 64'h300);
        bus_ready = 1;
        tick();
        bus_ready = 0;
        flush_w1 = 1;
        tick();
        flush_w1 = 0;
        bus_rvalid = 1; bus_rdata = 32'h12345678;
        tick();
        bus_rvalid = 0;
        check("t3 non-owner flush rvalid_w0", 64'(rvalid_w0), 64'd1);
        check("t3 non-owner flush rdata", 64'(rdata), 64'h12345678);

        // Owner flush in the same cycle as bus_rvalid
        req_w1 = 1; addr_w1 = 32'h400;
        tick();
        req_w1 = 0;
        check("t3b grant_w1", 64'(grant_w1), 64'd1);
        bus_ready = 1;
        tick();
        bus_ready = 0;
        bus_rvalid = 1; bus_rdata = 32'h0666; flush_w1 = 1;
        tick();
        bus_rvalid = 0; flush_w1 = 0;
        check_quiet("t3b same-cycle drop");

        // A flushed way's request in IDLE is not granted
        req_w0 = 1; flush_w0 = 1;
        tick();
        req_w0 = 0; flush_w0 = 0;
        check("t3c flushed req grant", 64'({grant_w0, grant_w1}), 64'd0);
        check("t3c flushed req bus_req", 64'(bus_req), 64'd0);

        // Address held while bus_ready stays low; stray rvalid ignored
        req_w0 = 1; addr_w0 = 32'hABC0;
        tick();
        check("t4 grant_w0", 64'(grant_w0), 64'd1);
        req_w1 = 1; addr_w0 = 32'hFFFF0;
        for (int i = 0; i < 5; i++) begin
            bus_rvalid = (i == 2);
            tick();
            check("t4 bus_req",  64'(bus_req), 64'd1);
            check("t4 bus_addr", 64'(bus_addr), 64'hABC0);
            check_quiet("t4 stall");
        end
        bus_rvalid = 0; bus_ready = 1;
        tick();
        bus_ready = 0; req_w0 = 0; req_w1 = 0;
        bus_rvalid = 1; bus_rdata = 32'h55;
        tick();
        bus_rvalid = 0;
        check("t4 rvalid_w0", 64'(rvalid_w0), 64'd1);
        check("t4 rdata",     64'(rdata), 64'h55);

        // Reset asserted in DATA, then an orphan response
        req_w1 = 1; addr_w1 = 32'h800;
        tick();
        req_w1 = 0;
        check("t5 grant_w1", 64'(grant_w1), 64'd1);
        bus_ready = 1;
        tick();
        bus_ready = 0;
        reset_n = 0;
        #1;
        check_quiet("t5 in reset");
        check("t5 reset bus_req", 64'(bus_req), 64'd0);
        check("t5 reset rdata",   64'(rdata), 64'd0);
        bus_rvalid = 1; bus_rdata = 32'h77;
        tick();
        reset_n = 1;
        tick();
        bus_rvalid = 0;
        check_quiet("t5 after reset");
        check("t5 after reset bus_req", 64'(bus_req), 64'd0);
        check("t5 after reset rdata",   64'(rdata), 64'd0);
        req_w0 = 1; req_w1 = 1; addr_w0 = 32'h10; addr_w1 = 32'h14;
        tick();
        req_w0 = 0; req_w1 = 0;
        check("t5 way0 first grant_w0", 64'(grant_w0), 64'd1);
        check("t5 way0 first grant_w1", 64'(grant_w1), 64'd0);
        bus_ready = 1;
        tick();
        bus_ready = 0;
        bus_rvalid = 1; bus_rdata = 32'h99;
        tick();
        bus_rvalid = 0;
        check("t5 rvalid_w0", 64'(rvalid_w0), 64'd1);

`ifdef FETCH_ARB_TIMEOUT_EN
        // Watchdog: 8 DATA cycles without a response
        req_w1 = 1; addr_w1 = 32'hC00;
        tick();
        req_w1 = 0;
        check("t6 grant_w1", 64'(grant_w1), 64'd1);
        bus_ready = 1;
        tick();
        bus_ready = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t6 err early", 64'(err), 64'd0);
        end
        tick();
        check("t6 err pulse", 64'(err), 64'd1);
        check("t6 no rvalid", 64'({rvalid_w0, rvalid_w1}), 64'd0);
        req_w0 = 1; addr_w0 = 32'hD00;
        tick();
        req_w0 = 0;
        check("t6 err cleared", 64'(err), 64'd0);
        check("t6 regrant",     64'(grant_w0), 64'd1);
        check("t6 bus_addr",    64'(bus_addr), 64'hD00);
`else
        // Without the watchdog DATA waits indefinitely and err_o stays low
        req_w1 = 1; addr_w1 = 32'hC00;
        tick();
        req_w1 = 0;
        bus_ready = 1;
        tick();
        bus_ready = 0;
        req_w0 = 1;
        for (int i = 0; i < 12; i++) tick();
        check("t6 err idle", 64'(err), 64'd0);
        check("t6 no regrant", 64'({grant_w0, grant_w1}), 64'd0);
        req_w0 = 0;
        bus_rvalid = 1; bus_rdata = 32'hCAFE;
        tick();
        bus_rvalid = 0;
        check("t6 late rvalid_w1", 64'(rvalid_w1), 64'd1);
        check("t6 late rdata",     64'(rdata), 64'hCAFE);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
